// File: rtl/main_memory_model.sv
// Behavioural main-memory model: line-wide RAM with written flags,
// fixed-latency in-order read pipeline and request counters.
module main_memory_model #(
    parameter int          LINE_W     = 128,
    parameter int          ADDR_W     = 32,
    parameter int          DEPTH_LOG2 = 8,
    parameter int          LATENCY    = 5,
    parameter int          ID_W       = 1,
    parameter logic [31:0] FILL_WORD  = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [LINE_W-1:0] data_in,
    input  logic              rden,
    input  logic              wren,
    input  logic [ID_W-1:0]   client_id_in,
    output logic [LINE_W-1:0] data_out,
    output logic              data_out_valid,
    output logic [ID_W-1:0]   client_id_out,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int OFS   = $clog2(LINE_W / 8);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LAST  = LATENCY - 1;

    logic [LINE_W-1:0]     mem [DEPTH];
    logic [DEPTH-1:0]      written;
    logic [DEPTH_LOG2-1:0] idx;
    logic [LINE_W-1:0]     rd_line;
    logic                  rd_acc;
    logic                  wr_acc;

    logic [LATENCY-1:0]    pipe_v;
    logic [ID_W-1:0]       pipe_id   [LATENCY];
    logic [LINE_W-1:0]     pipe_line [LATENCY];

    assign idx    = addr_in[OFS+DEPTH_LOG2-1:OFS];
    assign rd_acc = en & rden;
    assign wr_acc = en & wren;

    // Write-first: a same-edge write forwards its data to the read.
    always_comb begin
        rd_line = {(LINE_W / 32){FILL_WORD}};
        if (wren)
            rd_line = data_in;
        else if (written[idx])
            rd_line = mem[idx];
    end

    // Line storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc)
            mem[idx] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            written  <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (wr_acc) begin
                written[idx] <= 1'b1;
                wr_count     <= wr_count + 16'd1;
            end
            if (rd_acc)
                rd_count <= rd_count + 16'd1;
        end
    end

    // Payload moves only behind a valid entry, so bubbles leave the
    // last response visible at the output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v          <= '0;
            pipe_id[LAST]   <= '0;
            pipe_line[LAST] <= '0;
        end else if (en) begin
            pipe_v[0] <= rden;
            if (rden) begin
                pipe_id[0]   <= client_id_in;
                pipe_line[0] <= rd_line;
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_id[i]   <= pipe_id[i-1];
                    pipe_line[i] <= pipe_line[i-1];
                end
            end
        end
    end

    assign data_out       = pipe_line[LAST];
    assign client_id_out  = pipe_id[LAST];
    assign data_out_valid = pipe_v[LAST];

endmodule

// File: tb/tb_main_memory_model.sv
// Directed bench for main_memory_model with default parameters.
module tb_main_memory_model;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [31:0]  addr_in;
    logic [127:0] data_in;
    logic         rden;
    logic         wren;
    logic [0:0]   client_id_in;
    logic [127:0] data_out;
    logic         data_out_valid;
    logic [0:0]   client_id_out;
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;

    int checks = 0;
    int failures = 0;

    localparam logic [127:0] FILL = {4{32'hDEADBEEF}};
    localparam logic [127:0] W1   = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] LA   = 128'hAAAA_0001;
    localparam logic [127:0] LB   = 128'hBBBB_0002;
    localparam logic [127:0] LC   = 128'hCCCC_0003;
    localparam logic [127:0] DX   = 128'h5A5A_1234_0000_FFFF_1111_2222_3333_4444;
    localparam logic [127:0] DY   = 128'h7777;

    main_memory_model dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .addr_in        (addr_in),
        .data_in        (data_in),
        .rden           (rden),
        .wren           (wren),
        .client_id_in   (client_id_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .client_id_out  (client_id_out),
        .rd_count       (rd_count),
        .wr_count       (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rden = 1'b0;
        wren = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b0;
        idle();
        cyc();
        cyc();
        reset = 1'b0;
        en    = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [127:0] d);
        addr_in = a;
        data_in = d;
        wren    = 1'b1;
        rden    = 1'b0;
        cyc();
        wren    = 1'b0;
    endtask

    initial begin
        bit seen;
        reset = 1'b1;
        en = 1'b0;
        addr_in = '0;
        data_in = '0;
        client_id_in = '0;
        idle();
        cyc();
        cyc();
        reset = 1'b0;
        en = 1'b1;
        chk("rst_valid", data_out_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_id", client_id_out, 0);
        chk("rst_rdcnt", rd_count, 0);
        chk("rst_wrcnt", wr_count, 0);

        // Unwritten line returns fill after exactly LATENCY edges
        addr_in = 32'h100;
        client_id_in = 1'b1;
        rden = 1'b1;
        cyc();
        rden = 1'b0;
        for (int i = 0; i < 4; i++) chk("lat_early", data_out_valid, 0);
        cyc(); chk("lat_e1", data_out_valid, 0);
        cyc(); chk("lat_e2", data_out_valid, 0);
        cyc(); chk("lat_e3", data_out_valid, 0);
        cyc();
        chk("fill_valid", data_out_valid, 1);
        chk("fill_data", data_out, FILL);
        chk("fill_id", client_id_out, 1);
        cyc();
        chk("fill_drop", data_out_valid, 0);
        chk("fill_persist", data_out, FILL);
        chk("id_persist", client_id_out, 1);

        // Write then read direct and aliased address
        do_reset();
        wr(32'h10, W1);
        rden = 1'b1;
        addr_in = 32'h10;
        client_id_in = 1'b0;
        cyc();
        addr_in = 32'h1010;
        client_id_in = 1'b1;
        cyc();
        rden = 1'b0;
        cyc(); cyc();
        chk("alias_pre", data_out_valid, 0);
        cyc();
        chk("alias_v0", data_out_valid, 1);
        chk("alias_d0", data_out, W1);
        chk("alias_i0", client_id_out, 0);
        cyc();
        chk("alias_v1", data_out_valid, 1);
        chk("alias_d1", data_out, W1);
        chk("alias_i1", client_id_out, 1);
        cyc();
        chk("alias_end", data_out_valid, 0);
        chk("alias_rdcnt", rd_count, 2);
        chk("alias_wrcnt", wr_count, 1);

        // Back-to-back reads in order
        do_reset();
        wr(32'h10, LA);
        wr(32'h20, LB);
        wr(32'h30, LC);
        rden = 1'b1;
        addr_in = 32'h10; client_id_in = 1'b0; cyc();
        addr_in = 32'h20; client_id_in = 1'b1; cyc();
        addr_in = 32'h30; client_id_in = 1'b0; cyc();
        rden = 1'b0;
        cyc();
        chk("b2b_pre", data_out_valid, 0);
        cyc();
        chk("b2b_v0", data_out_valid, 1);
        chk("b2b_d0", data_out, LA);
        chk("b2b_i0", client_id_out, 0);
        cyc();
        chk("b2b_v1", data_out_valid, 1);
        chk("b2b_d1", data_out, LB);
        chk("b2b_i1", client_id_out, 1);
        cyc();
        chk("b2b_v2", data_out_valid, 1);
        chk("b2b_d2", data_out, LC);
        chk("b2b_i2", client_id_out, 0);
        cyc();
        chk("b2b_end", data_out_valid, 0);
        chk("b2b_persist", data_out, LC);

        // Enable stall mid-flight; requests during stall are dropped
        do_reset();
        wr(32'h40, DY);
        addr_in = 32'h40;
        client_id_in = 1'b1;
        rden = 1'b1;
        cyc();
        en = 1'b0;
        wren = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_v", data_out_valid, 0);
        end
        idle();
        en = 1'b1;
        chk("stall_rdcnt", rd_count, 1);
        chk("stall_wrcnt", wr_count, 1);
        cyc(); cyc(); cyc();
        chk("stall_pre", data_out_valid, 0);
        cyc();
        chk("stall_v1", data_out_valid, 1);
        chk("stall_d", data_out, DY);
        en = 1'b0;
        cyc(); cyc();
        chk("hold_v", data_out_valid, 1);
        chk("hold_d", data_out, DY);
        chk("hold_id", client_id_out, 1);
        en = 1'b1;
        cyc();
        chk("hold_drop", data_out_valid, 0);

        // Simultaneous read and write is write-first
        do_reset();
        wr(32'h20, DY);
        addr_in = 32'h20;
        data_in = DX;
        rden = 1'b1;
        wren = 1'b1;
        client_id_in = 1'b0;
        cyc();
        idle();
        cyc(); cyc(); cyc(); cyc();
        chk("rw_v", data_out_valid, 1);
        chk("rw_d", data_out, DX);
        chk("rw_rdcnt", rd_count, 1);
        chk("rw_wrcnt", wr_count, 2);

        // Reset flushes in-flight read; request on reset edge dropped
        do_reset();
        addr_in = 32'h20;
        rden = 1'b1;
        cyc();
        rden = 1'b0;
        cyc();
        reset = 1'b1;
        rden = 1'b1;
        wren = 1'b1;
        cyc();
        reset = 1'b0;
        idle();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (data_out_valid) seen = 1'b1;
        end
        chk("flush_none", seen, 0);
        chk("flush_rdcnt", rd_count, 0);
        chk("flush_wrcnt", wr_count, 0);
        chk("flush_data", data_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_memory_model.md
MAIN_MEMORY_MODEL -- requirements
Module: main_memory_model

Interface
REQ-001 Parameter LINE_W, default 128: cache-line width in bits; multiple of 32.
REQ-002 Parameter ADDR_W, default 32: byte-address width.
REQ-003 Parameter DEPTH_LOG2, default 8: log2 of the number of stored lines.
REQ-004 Parameter LATENCY, default 5: read response latency in enabled clock edges; range 1..16.
REQ-005 Parameter ID_W, default 1: client-ID width.
REQ-006 Parameter FILL_WORD, default 32'hDEADBEEF: 32-bit pattern returned for lines never written.
REQ-007 Port clk, input, 1: clock; all logic on the rising edge.
REQ-008 Port reset, input, 1: synchronous, active-high reset.
REQ-009 Port en, input, 1: global enable; 0 freezes all state.
REQ-010 Port addr_in, input, ADDR_W: byte address of the request.
REQ-011 Port data_in, input, LINE_W: write line.
REQ-012 Port rden, input, 1: read request.
REQ-013 Port wren, input, 1: write request.
REQ-014 Port client_id_in, input, ID_W: requester tag.
REQ-015 Port data_out, output, LINE_W: read response line.
REQ-016 Port data_out_valid, output, 1: read response valid.
REQ-017 Port client_id_out, output, ID_W: tag of the response.
REQ-018 Port rd_count, output, 16: accepted reads; wraps 16'hFFFF->0.
REQ-019 Port wr_count, output, 16: accepted writes; wraps 16'hFFFF->0.

Function
REQ-020 Line index SHALL be addr_in[OFS+DEPTH_LOG2-1:OFS], with OFS=log2(LINE_W/8); all other address bits are ignored, so addresses alias.
REQ-021 A request SHALL be accepted only on a rising edge where en=1; when en=0, rden/wren SHALL be ignored, not queued.
REQ-022 An accepted write SHALL store data_in at the indexed line and set that line's written flag.
REQ-023 An accepted read SHALL capture the line at acceptance: the stored line if its written flag is set, else FILL_WORD replicated LINE_W/32 times.
REQ-024 When rden and wren are both accepted on the same edge, the write SHALL occur and the read SHALL return data_in (write-first).
REQ-025 A read accepted at enabled edge N SHALL be presented with data_out_valid=1 after enabled edge N+LATENCY-1, i.e. LATENCY enabled edges counting N.
REQ-026 data_out, client_id_out and data_out_valid SHALL come from the same pipeline stage.
REQ-027 The pipeline SHALL be a LATENCY-deep shift register of {valid, id, line}.
REQ-028 The pipeline SHALL accept one read per enabled cycle, giving back-to-back responses with no bubbles.
REQ-029 Responses SHALL be returned in acceptance order.
REQ-030 When en=0, all pipeline stages, outputs and counters SHALL hold their values; a response already valid stays asserted until the next enabled edge.
REQ-031 Outputs SHALL update only on enabled edges; the last response's data_out and client_id_out SHALL persist after data_out_valid drops.
REQ-032 rd_count SHALL increment on each accepted read, and wr_count on each accepted write, both mod 2^16; simultaneous rden and wren SHALL increment both.

Reset
REQ-033 Reset SHALL clear all written flags, all pipeline valid bits, data_out (to 0), client_id_out (to 0), data_out_valid (to 0), rd_count and wr_count.
REQ-034 Reset SHALL NOT be required to clear the stored line contents.
REQ-035 Reset SHALL take priority over en.
REQ-036 Reset SHALL discard all in-flight reads, with no response emitted afterwards.
REQ-037 A request presented on a reset edge SHALL NOT be accepted.

Verification
REQ-038 After reset, read addr 0x100 with id 1 -> data_out_valid=1 with data_out=128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF and client_id_out=1 exactly 5 enabled edges later, valid for 1 cycle.
REQ-039 Write 0x0123...CDEF to addr 0x10, then read addr 0x10 and alias addr 0x1010 (DEPTH_LOG2=8) -> both return the written line; rd_count=2, wr_count=1.
REQ-040 Reads to lines 1,2,3 on consecutive edges with ids 0,1,0 -> three consecutive valid cycles, in order, with matching ids.
REQ-041 Read accepted, then en=0 held 3 cycles mid-flight -> response arrives 3 cycles later than nominal, and outputs hold while en=0.
REQ-042 rden and wren on the same edge to addr 0x20 with data X -> response=X and both counters increment.
REQ-043 Read accepted, then reset asserted 2 edges later -> no data_out_valid ever appears, and counters are 0.
